// File: rtl/bcd_counter_n_if.sv
// Control/data bundle for the N-digit BCD counter.
// The master drives the controls and load value; the slave returns the count and status.
interface bcd_counter_n_if #(
  parameter int unsigned DIGITS = 3
);
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic                  en;
  logic                  up;
  logic                  sat;
  logic [4*DIGITS-1:0]   q;
  logic                  ovf;
  logic                  unf;
  logic                  lderr;
  logic                  zero;
  logic                  max;

  modport master (
    output clr, load, din, en, up, sat,
    input  q, ovf, unf, lderr, zero, max
  );

  modport slave (
    input  clr, load, din, en, up, sat,
    output q, ovf, unf, lderr, zero, max
  );
endinterface

// File: rtl/bcd_counter_n.sv
// N-digit packed-BCD up/down counter with validated parallel load,
// wrap/saturate boundary handling and one-cycle overflow/underflow/load-error pulses.
module bcd_counter_n #(
  parameter int unsigned DIGITS = 3
) (
  input  logic            clk,
  input  logic            reset,
  bcd_counter_n_if.slave  bus
);
  localparam int unsigned W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'd9}};

  logic [W-1:0]      q_q, q_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              lderr_q, lderr_d;

  logic [W-1:0]      inc_w, dec_w;
  logic [DIGITS:0]   carry, borrow;
  logic [DIGITS-1:0] dig_nine, dig_zero, din_ok;
  logic              at_max, at_zero, din_valid;

  // Each digit owns its own carry/borrow; the chain end doubles as the all-nines / all-zeros detect.
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] d;
    logic [3:0] ld;

    assign d  = q_q[4*i +: 4];
    assign ld = bus.din[4*i +: 4];

    assign dig_nine[i] = (d == 4'd9);
    assign dig_zero[i] = (d == 4'd0);
    assign din_ok[i]   = (ld <= 4'd9);

    assign carry[i+1]  = carry[i]  & dig_nine[i];
    assign borrow[i+1] = borrow[i] & dig_zero[i];

    assign inc_w[4*i +: 4] = !carry[i]  ? d : (dig_nine[i] ? 4'd0 : d + 4'd1);
    assign dec_w[4*i +: 4] = !borrow[i] ? d : (dig_zero[i] ? 4'd9 : d - 4'd1);
  end

  assign at_max    = carry[DIGITS];
  assign at_zero   = borrow[DIGITS];
  assign din_valid = &din_ok;

  always_comb begin
    q_d     = q_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    lderr_d = 1'b0;

    if (bus.clr) begin
      q_d = '0;
    end else if (bus.load) begin
      if (din_valid) begin
        q_d = bus.din;
      end else begin
        lderr_d = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_max) begin
          ovf_d = 1'b1;
          q_d   = bus.sat ? ALL_NINES : '0;
        end else begin
          q_d = inc_w;
        end
      end else begin
        if (at_zero) begin
          unf_d = 1'b1;
          q_d   = bus.sat ? '0 : ALL_NINES;
        end else begin
          q_d = dec_w;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      lderr_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      lderr_q <= lderr_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.lderr = lderr_q;
  assign bus.zero  = at_zero;
  assign bus.max   = at_max;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: integer-valued reference model checked every cycle,
// directed literal expectations followed by randomized stimulus.
module tb_bcd_counter_n;
  localparam int D    = 3;
  localparam int W    = 4 * D;
  localparam int MAXV = 10**D - 1;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en   = 1'b0;

  bcd_counter_n_if #(.DIGITS(D)) bus ();
  bcd_counter_n #(.DIGITS(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] b;
    int t;
    b = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic bit bcd_ok(input logic [W-1:0] b);
    for (int i = 0; i < D; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the count as a plain integer in 0..MAXV.
  int m_q;
  bit m_ovf, m_unf, m_lderr;

  always @(posedge clk) begin
    if (reset) begin
      m_q <= 0; m_ovf <= 1'b0; m_unf <= 1'b0; m_lderr <= 1'b0;
    end else begin
      m_ovf <= 1'b0; m_unf <= 1'b0; m_lderr <= 1'b0;
      if (bus.clr) m_q <= 0;
      else if (bus.load) begin
        if (bcd_ok(bus.din)) m_q <= bcd2int(bus.din);
        else m_lderr <= 1'b1;
      end else if (bus.en) begin
        if (bus.up) begin
          if (m_q == MAXV) begin m_ovf <= 1'b1; m_q <= bus.sat ? MAXV : 0; end
          else m_q <= m_q + 1;
        end else begin
          if (m_q == 0) begin m_unf <= 1'b1; m_q <= bus.sat ? 0 : MAXV; end
          else m_q <= m_q - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_q",     32'(bus.q),     32'(int2bcd(m_q)));
      chk("model_ovf",   32'(bus.ovf),   32'(m_ovf));
      chk("model_unf",   32'(bus.unf),   32'(m_unf));
      chk("model_lderr", 32'(bus.lderr), 32'(m_lderr));
      chk("model_zero",  32'(bus.zero),  32'(m_q == 0));
      chk("model_max",   32'(bus.max),   32'(m_q == MAXV));
    end
  end

  // Drive one cycle of inputs, let the edge process them, return 2ns after that edge.
  task automatic apply(input logic r, input logic c, input logic l, input logic [W-1:0] d,
                       input logic e, input logic u, input logic s);
    reset = r; bus.clr = c; bus.load = l; bus.din = d; bus.en = e; bus.up = u; bus.sat = s;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [W-1:0] eq, input logic eovf,
                     input logic eunf, input logic elderr);
    chk({name, "_q"},     32'(bus.q),     32'(eq));
    chk({name, "_ovf"},   32'(bus.ovf),   32'(eovf));
    chk({name, "_unf"},   32'(bus.unf),   32'(eunf));
    chk({name, "_lderr"}, 32'(bus.lderr), 32'(elderr));
  endtask

  initial begin
    logic [W-1:0] rd;
    apply(1, 0, 0, '0, 0, 1, 0);
    chk_en = 1'b1;
    lit("reset", 12'h000, 0, 0, 0);
    chk("reset_zero", 32'(bus.zero), 32'd1);
    chk("reset_max",  32'(bus.max),  32'd0);

    apply(0, 0, 1, 12'h129, 0, 1, 0); lit("load129", 12'h129, 0, 0, 0);
    apply(0, 1, 0, 12'h000, 0, 1, 0); lit("clr", 12'h000, 0, 0, 0);

    apply(0, 0, 1, 12'h099, 0, 1, 0);
    apply(0, 0, 0, 12'h000, 1, 1, 0); lit("ripple100", 12'h100, 0, 0, 0);
    apply(0, 0, 0, 12'h000, 1, 1, 0); lit("ripple101", 12'h101, 0, 0, 0);
    apply(0, 0, 1, 12'h909, 0, 1, 0);
    apply(0, 0, 0, 12'h000, 1, 1, 0); lit("ripple910", 12'h910, 0, 0, 0);

    apply(0, 0, 1, 12'h999, 0, 1, 0);
    apply(0, 0, 0, 12'h000, 1, 1, 0); lit("wrap_up", 12'h000, 1, 0, 0);
    apply(0, 0, 0, 12'h000, 0, 1, 0); lit("wrap_up_clear", 12'h000, 0, 0, 0);
    apply(0, 0, 1, 12'h999, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, 12'h000, 1, 1, 1); lit("sat_up", 12'h999, 1, 0, 0);
      chk("sat_up_max", 32'(bus.max), 32'd1);
    end

    apply(0, 0, 1, 12'h100, 0, 0, 0);
    apply(0, 0, 0, 12'h000, 1, 0, 0); lit("borrow099", 12'h099, 0, 0, 0);
    apply(0, 0, 1, 12'h000, 0, 0, 0);
    apply(0, 0, 0, 12'h000, 1, 0, 0); lit("wrap_dn", 12'h999, 0, 1, 0);
    apply(0, 0, 1, 12'h000, 0, 0, 1);
    apply(0, 0, 0, 12'h000, 1, 0, 1); lit("sat_dn", 12'h000, 0, 1, 0);

    apply(0, 0, 1, 12'h456, 0, 1, 0);
    apply(0, 0, 1, 12'h1A3, 0, 1, 0); lit("bad_load", 12'h456, 0, 0, 1);
    apply(0, 0, 0, 12'h000, 0, 1, 0); lit("bad_load_clear", 12'h456, 0, 0, 0);
    apply(0, 0, 1, 12'h050, 1, 1, 0); lit("load_over_en", 12'h050, 0, 0, 0);
    apply(0, 1, 1, 12'h123, 1, 1, 0); lit("clr_over_load", 12'h000, 0, 0, 0);

    apply(0, 0, 1, 12'h995, 0, 1, 0);
    apply(0, 0, 0, 12'h000, 1, 1, 0); lit("mid996", 12'h996, 0, 0, 0);
    apply(0, 0, 0, 12'h000, 1, 1, 0); lit("mid997", 12'h997, 0, 0, 0);
    apply(1, 0, 0, 12'h000, 1, 1, 0); lit("mid_reset", 12'h000, 0, 0, 0);
    apply(0, 0, 0, 12'h000, 0, 1, 0); lit("post_reset", 12'h000, 0, 0, 0);

    for (int k = 0; k < 3000; k++) begin
      case ($urandom % 4)
        0: rd = W'($urandom);
        1: rd = int2bcd(MAXV);
        2: rd = '0;
        default: rd = int2bcd(int'($urandom % (MAXV + 1)));
      endcase
      apply(($urandom % 64) == 0, ($urandom % 32) == 0, ($urandom % 8) == 0, rd,
            ($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 2) == 1);
    end

    apply(0, 0, 0, '0, 0, 1, 0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
- Parametrised N-digit BCD up/down counter; the clocked successor to the team's combinational three-digit BCD incrementer.
- Holds a packed BCD value and counts up or down by one per enabled clock.
- Supports synchronous parallel load with BCD validation.
- Supports runtime-selectable wrap or saturate at the range limits, with registered overflow/underflow pulses.
- Used as the display/event counter ahead of the seven-segment multiplexer.

Parameters:
- DIGITS, 3, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of the count to 0.
- load  in  1  parallel-load strobe.
- din  in  4*DIGITS  packed BCD load value; digit 0 (ones) in [3:0].
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  boundary mode: 1 = saturate, 0 = wrap.
- q  out  4*DIGITS  current count, packed BCD, registered.
- ovf  out  1  registered pulse: an enabled up-count hit the max value 9..9.
- unf  out  1  registered pulse: an enabled down-count hit 0..0.
- lderr  out  1  registered pulse: load was rejected because din held a digit greater than 9.
- zero  out  1  combinational: q == all zeros.
- max  out  1  combinational: q == all nines.

Behaviour:
- All state updates on the rising edge of clk. ovf, unf and lderr default to 0 in every cycle unless set below.
- Reset (reset=1):
  - q=0, ovf=0, unf=0, lderr=0; zero=1, max=0 follow from q.
  - Reset overrides every other input in that cycle, including mid-count and mid-load.
- Priority when not in reset: clr > load > en. Only the highest-priority active operation takes effect.
- clr=1: q=0. No pulses.
- load=1:
  - If every digit of din is 9 or less, q=din, lderr=0.
  - Otherwise q is held and lderr=1 for one cycle.
  - en is ignored in a load cycle, whether the load is accepted or rejected.
- en=1, up=1, q != max:
  - Ripple BCD increment. Digit i increments when all lower digits are 9; each digit at 9 that rolls becomes 0.
  - Latency is one clock. There is no multi-cycle ripple.
- en=1, up=1, q == max:
  - sat=0: q becomes all zeros, ovf=1.
  - sat=1: q is held at all nines, ovf=1.
- en=1, up=0, q != 0:
  - Ripple BCD decrement. Digit i decrements when all lower digits are 0; each digit at 0 that borrows becomes 9.
- en=1, up=0, q == 0:
  - sat=0: q becomes all nines, unf=1.
  - sat=1: q is held at 0, unf=1.
- en=0 with no clr/load: q is held.
- ovf/unf timing:
  - Each is high for exactly one cycle after the edge that processed the boundary count.
  - With en held high in saturate mode at a boundary, the pulse re-asserts every cycle.
- up and sat are sampled only in enabled count cycles and may change freely otherwise.
- Invariant: q never contains a digit greater than 9.
- Width rule: no binary adder across digit boundaries. Each digit is a 4-bit field with its own carry/borrow chain.
- DIGITS=1 is legal: range 0..9, zero and max refer to the single digit.

Test Plan (DIGITS=3):
- Reset/load/clear: reset=1 -> q=000, zero=1. Then load din=0x129 -> q=0x129. Then clr -> q=000.
- Carry ripple up: load 0x099, en=1, up=1, two clocks -> q=0x100 then 0x101, ovf=0 throughout. Load 0x909, one clock -> 0x910.
- Wrap up / saturate up: load 0x999, sat=0, one clock -> q=0x000 with ovf=1 for one cycle. Reload 0x999, sat=1, three clocks -> q stays 0x999, ovf=1 each cycle, max=1.
- Borrow down and underflow: load 0x100, up=0, one clock -> 0x099. From 0x000 with sat=0 -> 0x999, unf=1. From 0x000 with sat=1 -> 0x000, unf=1.
- Invalid load and priority: load din=0x1A3 -> q unchanged, lderr=1 for one cycle. load=1 and en=1 with din=0x050 -> q=0x050, no count. clr=1 and load=1 -> q=000.
- Reset mid-count: en=1 counting up from 0x995; assert reset on the third edge -> q=000, ovf=0, with no wrap pulse leaking after reset.
